// File: rtl/pio_gpio_pkg.sv
// Shared constants for the GPIO slave: register word offsets and edge-select codes.
package pio_gpio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_gpio_irq_if.sv
// Avalon-MM slave bus bundle for the GPIO block; readdata is zero-wait combinational.
interface pio_gpio_irq_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/pio_edge_sync.sv
// Input synchroniser chain, previous-sample register and per-bit edge detection.
module pio_edge_sync
    import pio_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] det
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]                  prev;
    logic [WIDTH-1:0]                  rise;
    logic [WIDTH-1:0]                  fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
            prev  <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pins};
            prev  <= sync_in;
        end
    end

    assign sync_in = chain[SYNC_STAGES-1];
    assign rise    = sync_in & ~prev;
    assign fall    = ~sync_in & prev;

    always_comb begin
        det = rise;
        if (EDGE_TYPE == EDGE_FALL)
            det = fall;
        else if (EDGE_TYPE == EDGE_ANY)
            det = rise | fall;
    end

endmodule

// File: rtl/pio_gpio_irq.sv
// GPIO slave: output/direction/mask registers, atomic set/clear, W1C edge capture
// and a registered level interrupt.
module pio_gpio_irq
    import pio_gpio_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_OUT   = '0,
    parameter logic [31:0] RESET_DIR   = '0,
    parameter int          EDGE_TYPE   = EDGE_RISE,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    pio_gpio_irq_if.slave    bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] dir_reg;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] edgecap_next;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] det;
    logic             wr;
    logic [31:0]      rd;
    logic             unused_wd;

    pio_edge_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_edge_sync (
        .clk     (clk),
        .reset   (reset),
        .pins    (in_port),
        .sync_in (sync_in),
        .det     (det)
    );

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign unused_wd = ^bus.writedata;

    // Detection is OR'd in after the clear so a same-cycle edge beats the W1C.
    always_comb begin
        clr          = (wr && bus.address == ADDR_EDGECAP) ? wd : '0;
        edgecap_next = (edgecap & ~clr) | det;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg  <= RESET_OUT[WIDTH-1:0];
            dir_reg  <= RESET_DIR[WIDTH-1:0];
            mask_reg <= '0;
            edgecap  <= '0;
            irq      <= 1'b0;
        end else begin
            edgecap <= edgecap_next;
            irq     <= |(edgecap_next & mask_reg);
            if (wr) begin
                case (bus.address)
                    ADDR_DATA:    out_reg  <= wd;
                    ADDR_DIR:     dir_reg  <= wd;
                    ADDR_IRQMASK: mask_reg <= wd;
                    ADDR_OUTSET:  out_reg  <= out_reg | wd;
                    ADDR_OUTCLR:  out_reg  <= out_reg & ~wd;
                    default: ;
                endcase
            end
        end
    end

    // DATA reads the synchronised pin, not out_reg, so output bits read back the pad.
    always_comb begin
        rd = '0;
        case (bus.address)
            ADDR_DATA:    rd = 32'(sync_in);
            ADDR_DIR:     rd = 32'(dir_reg);
            ADDR_IRQMASK: rd = 32'(mask_reg);
            ADDR_EDGECAP: rd = 32'(edgecap);
            ADDR_OUTSET,
            ADDR_OUTCLR:  rd = 32'(out_reg);
            default:      rd = '0;
        endcase
    end

    assign bus.readdata = rd;
    assign out_port     = out_reg;
    assign oe_port      = dir_reg;

endmodule

// File: tb/tb_pio_gpio_irq.sv
// Directed bench: rising-edge 8-bit DUT (A), any-edge 8-bit DUT (B), 4-bit decode DUT (C).
module tb_pio_gpio_irq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pio_gpio_irq_if ifa ();
    pio_gpio_irq_if ifb ();
    pio_gpio_irq_if ifc ();

    logic [7:0] in_a, in_b, out_a, out_b, oe_a, oe_b;
    logic [3:0] in_c, out_c, oe_c;
    logic       irq_a, irq_b, irq_c;

    int n_chk  = 0;
    int n_fail = 0;

    pio_gpio_irq #(.WIDTH(8), .RESET_OUT(32'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa), .in_port(in_a),
        .out_port(out_a), .oe_port(oe_a), .irq(irq_a));

    pio_gpio_irq #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb), .in_port(in_b),
        .out_port(out_b), .oe_port(oe_b), .irq(irq_b));

    pio_gpio_irq #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_c (
        .clk(clk), .reset(reset), .bus(ifc), .in_port(in_c),
        .out_port(out_c), .oe_port(oe_c), .irq(irq_c));

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic [2:0] a, input logic cs, input logic wn,
                         input logic [31:0] v);
        case (d)
            0: begin ifa.address = a; ifa.chipselect = cs; ifa.write_n = wn; ifa.writedata = v; end
            1: begin ifb.address = a; ifb.chipselect = cs; ifb.write_n = wn; ifb.writedata = v; end
            default: begin ifc.address = a; ifc.chipselect = cs; ifc.write_n = wn; ifc.writedata = v; end
        endcase
    endtask

    // One bus cycle ending on the next clock edge; strobes are released afterwards.
    task automatic bwr(input int d, input logic [2:0] a, input logic [31:0] v,
                       input logic cs = 1'b1, input logic wn = 1'b0);
        drive(d, a, cs, wn, v);
        tick(1);
        drive(d, 3'd0, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic rchk(input string tag, input int d, input logic [2:0] a,
                        input logic [31:0] exp);
        logic [31:0] v;
        drive(d, a, 1'b1, 1'b1, 32'h0);
        #1;
        case (d)
            0:       v = ifa.readdata;
            1:       v = ifb.readdata;
            default: v = ifc.readdata;
        endcase
        drive(d, 3'd0, 1'b0, 1'b1, 32'h0);
        chk(tag, v, exp);
    endtask

    initial begin
        reset = 1'b1;
        in_a = '0; in_b = '0; in_c = '0;
        for (int d = 0; d < 3; d++) drive(d, 3'd0, 1'b0, 1'b1, 32'h0);
        tick(3);
        reset = 1'b0;

        // Reset state
        chk("rst_out_a", 32'(out_a), 32'hA5);
        chk("rst_oe_a",  32'(oe_a),  32'h00);
        chk("rst_irq_a", 32'(irq_a), 32'h0);
        rchk("rst_edgecap_a", 0, 3'd3, 32'h0);
        rchk("rst_mask_a",    0, 3'd2, 32'h0);
        chk("rst_out_c", 32'(out_c), 32'h0);

        // Load / set / clear
        bwr(0, 3'd0, 32'h0F); chk("data_wr", 32'(out_a), 32'h0F);
        bwr(0, 3'd4, 32'h30); chk("outset",  32'(out_a), 32'h3F);
        bwr(0, 3'd5, 32'h03); chk("outclr",  32'(out_a), 32'h3C);
        rchk("rd_outset", 0, 3'd4, 32'h3C);
        rchk("rd_outclr", 0, 3'd5, 32'h3C);
        bwr(0, 3'd1, 32'h5A); chk("dir_oe", 32'(oe_a), 32'h5A);
        rchk("rd_dir", 0, 3'd1, 32'h5A);
        rchk("rd_data_pin", 0, 3'd0, 32'h00);

        // Rising edge on bit 2: visible after SYNC_STAGES+1 edges
        in_a = 8'h04; in_b = 8'h04;
        tick(2);
        rchk("edge_not_yet", 0, 3'd3, 32'h00);
        rchk("sync_data",    0, 3'd0, 32'h04);
        tick(1);
        rchk("edge_rise_a", 0, 3'd3, 32'h04);
        rchk("edge_rise_b", 1, 3'd3, 32'h04);
        bwr(1, 3'd3, 32'h04);
        rchk("w1c_b", 1, 3'd3, 32'h00);

        // Falling edge: captured only by the any-edge instance
        in_a = 8'h00; in_b = 8'h00;
        tick(4);
        rchk("fall_a_none", 0, 3'd3, 32'h04);
        rchk("fall_b_cap",  1, 3'd3, 32'h04);
        bwr(0, 3'd3, 32'h04);
        rchk("w1c_a", 0, 3'd3, 32'h00);

        // Masked interrupt
        bwr(0, 3'd2, 32'h04);
        chk("irq_idle", 32'(irq_a), 32'h0);
        in_a = 8'h04;
        tick(4);
        rchk("irq_edgecap", 0, 3'd3, 32'h04);
        chk("irq_set", 32'(irq_a), 32'h1);
        bwr(0, 3'd3, 32'h04);
        tick(1);
        chk("irq_w1c", 32'(irq_a), 32'h0);

        // Mask=0 blocks irq though capture still happens
        bwr(0, 3'd2, 32'h00);
        in_a = 8'h00; tick(4);
        in_a = 8'h04; tick(4);
        rchk("nomask_cap", 0, 3'd3, 32'h04);
        chk("nomask_irq", 32'(irq_a), 32'h0);
        bwr(0, 3'd2, 32'h04);
        tick(1);
        chk("mask_on_irq", 32'(irq_a), 32'h1);

        // W1C on the same edge as a new detection: the bit stays set
        in_a = 8'h00; tick(4);
        in_a = 8'h04;
        tick(2);
        bwr(0, 3'd3, 32'h04);
        rchk("simul_cap", 0, 3'd3, 32'h04);
        chk("simul_irq", 32'(irq_a), 32'h1);
        tick(1);
        chk("simul_irq2", 32'(irq_a), 32'h1);

        // Width truncation and decode on the 4-bit instance
        bwr(2, 3'd1, 32'hFFFF_FFFF);
        rchk("w4_dir", 2, 3'd1, 32'h0000_000F);
        chk("w4_oe", 32'(oe_c), 32'hF);
        bwr(2, 3'd6, 32'hFFFF_FFFF);
        bwr(2, 3'd7, 32'hFFFF_FFFF);
        rchk("rd_addr6", 2, 3'd6, 32'h0);
        rchk("rd_addr7", 2, 3'd7, 32'h0);
        rchk("w4_mask_untouched", 2, 3'd2, 32'h0);
        chk("w4_out_untouched", 32'(out_c), 32'h0);
        bwr(2, 3'd0, 32'hF, 1'b0, 1'b0);
        chk("cs0_ignored", 32'(out_c), 32'h0);
        bwr(2, 3'd0, 32'hF, 1'b1, 1'b1);
        chk("wn1_ignored", 32'(out_c), 32'h0);
        bwr(2, 3'd0, 32'h9);
        chk("w4_data", 32'(out_c), 32'h9);

        // Reset mid-operation clears pending capture and irq
        reset = 1'b1; tick(1); reset = 1'b0;
        rchk("rst2_edgecap", 0, 3'd3, 32'h0);
        chk("rst2_irq", 32'(irq_a), 32'h0);
        chk("rst2_out", 32'(out_a), 32'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
